rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline writeback and one long-latency unit (divider). The long-latency unit is referred to below as LU.
- Pipeline writeback always has priority.
- LU results are buffered in a small FIFO and drain on idle port cycles.
- The block exports a hazard signal for decode and a port-steal request that forces a pipeline bubble when the queue starves.
- It sits between the wb stage, the LU and the register file.

Parameters:
DEPTH, 2, LU result queue entries (power of two, at least 2).
STARVE_LIMIT, 4, cycles a non-empty queue may wait before steal_o asserts (at least 1).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
wb_w_reg_enable_i  in  1  pipeline writeback valid (`write_enable)
wb_w_reg_addr_i  in  5  pipeline destination register
wb_w_reg_data_i  in  32  pipeline writeback data
lu_valid_i  in  1  LU result valid
lu_ready_o  out  1  arbiter can accept an LU result
lu_reg_addr_i  in  5  LU destination register
lu_reg_data_i  in  32  LU result data
id_rs1_addr_i  in  5  decode source register 1
id_rs2_addr_i  in  5  decode source register 2
id_rd_addr_i  in  5  decode destination register
hazard_o  out  1  decode must stall (RAW/WAW against a queued LU result)
steal_o  out  1  request to pipeline: insert a writeback bubble next cycle
w_reg_enable_o  out  1  register-file write enable
w_reg_addr_o  out  5  register-file write address
w_reg_data_o  out  32  register-file write data

Behaviour:
- Single clock. Reset is asynchronous and active-low.
- Reset state: queue empty, pointers 0, starve counter 0, steal_o 0.
- Outputs during reset:
  - lu_ready_o = 1, hazard_o = 0.
  - w_reg_enable_o reflects wb_w_reg_enable_i only; no queued write is issued.
- Port mux (combinational, 0 latency), first match wins:
  - P1: wb_w_reg_enable_i=1 drives the port with the wb address and data.
  - P2: queue non-empty drives the port with the queue head; head is popped at the clock edge.
  - P3: queue empty and LU handshake (lu_valid_i & lu_ready_o) with a nonzero address writes the LU result directly (bypass, not enqueued).
  - Otherwise w_reg_enable_o=0, and address/data are 0.
- LU handshake:
  - lu_ready_o = !full, computed from registered state only; no combinational path from lu_valid_i.
  - An accepted LU result with address 0 is discarded: not enqueued, no port write.
  - An accepted nonzero result not bypassed is enqueued at the tail.
  - Enqueue and pop in the same cycle are legal, and the count stays the same.
  - Full (count == DEPTH): lu_ready_o=0; the LU holds its data.
- Ordering: LU results retire in acceptance order. Wrap-around uses DEPTH-modulo pointers with a separate count of log2(DEPTH)+1 bits.
- Hazard:
  - hazard_o=1 if any valid queue entry's address equals a nonzero id_rs1_addr_i, id_rs2_addr_i or id_rd_addr_i.
  - Combinational; uses the pre-pop state (conservative by one cycle).
- Starvation:
  - The counter increments each cycle the queue is non-empty and wb holds the port.
  - It clears to 0 on any pop or when the queue is empty, and saturates at STARVE_LIMIT.
  - steal_o is registered and =1 while counter == STARVE_LIMIT.
  - The pipeline responds with wb_w_reg_enable_i=0 on the next cycle, which pops the head and clears the counter and steal_o.
  - If wb stays asserted anyway, wb still wins and steal_o stays high.
- Reset mid-operation: queue contents are lost and all state returns to the reset values immediately (asynchronous).

Decomposition:
- Shared define file: reg_addr_bus, reg_data_bus, write_enable/write_disable, data_zero, reg_zero_addr.
- Natural sub-module: rf_wq_fifo (parameterised sync FIFO with count, exposing per-entry valid and address for the hazard compare).
- Mux, starve counter and hazard compare stay in the top module.

Test Plan:
1. Reset; LU result x5=0x1234 with wb idle -> same-cycle w_reg_enable_o=1, addr 5, data 0x1234; queue stays empty; hazard_o=0.
2. wb writes x1 each cycle while the LU sends x7=0xA then x8=0xB -> both enqueue; lu_ready_o=0 after the second; id_rs1_addr_i=7 gives hazard_o=1; wb drops -> x7 written, then x8, in order.
3. wb busy continuously with one entry queued -> steal_o rises after 4 cycles; next cycle wb=0 -> head written, steal_o=0, counter=0.
4. LU result with address 0 -> handshake completes, w_reg_enable_o=0, count unchanged.
5. Queue full and a pop coincides with lu_valid_i -> no accept that cycle (lu_ready_o=0); accepted next cycle; count 2->1->2; pointer wraps correctly.
6. rst_n low with 2 entries queued -> asynchronously empty; lu_ready_o=1, steal_o=0, hazard_o=0.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared register-file write-port types and constants.
// No logic; imported by the arbiter and its LU result queue.
// Backpressure: not applicable.
package rf_wport_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_bus;
    typedef logic [REG_DATA_W-1:0] reg_data_bus;

    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam reg_data_bus DATA_ZERO     = '0;
    localparam reg_addr_bus REG_ZERO_ADDR = '0;

    typedef struct packed {
        reg_addr_bus addr;
        reg_data_bus data;
    } lu_entry_t;
endpackage

// File: rtl/rf_wq_fifo.sv
// LU result queue: sync FIFO with occupancy count and per-entry valid/address taps.
// Latency: head visible the cycle after push; pop takes effect at the clock edge.
// Backpressure: caller must not push when count == DEPTH.
module rf_wq_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  lu_entry_t                   push_dat,
    input  logic                        pop,
    output lu_entry_t                   head_dat,
    output logic [CW-1:0]               count,
    output logic [DEPTH-1:0]            ent_vld,
    output reg_addr_bus [DEPTH-1:0]     ent_addr
);
    lu_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        off      = '0;
        ent_vld  = '0;
        ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = PW'(i) - rd_ptr;
            ent_vld[i]  = (CW'(off) < count);
            ent_addr[i] = mem[i].addr;
        end
    end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: wb first, then queued LU results, then LU bypass.
// Latency: 0 cycles combinational port mux; steal_o is registered.
// Backpressure: lu_ready_o drops while the LU queue is full (from registered state only).
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_w_reg_enable_i,
    input  reg_addr_bus wb_w_reg_addr_i,
    input  reg_data_bus wb_w_reg_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  reg_addr_bus lu_reg_addr_i,
    input  reg_data_bus lu_reg_data_i,
    input  reg_addr_bus id_rs1_addr_i,
    input  reg_addr_bus id_rs2_addr_i,
    input  reg_addr_bus id_rd_addr_i,
    output logic        hazard_o,
    output logic        steal_o,
    output logic        w_reg_enable_o,
    output reg_addr_bus w_reg_addr_o,
    output reg_data_bus w_reg_data_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    lu_entry_t              q_head;
    logic [CW-1:0]          q_count;
    logic [DEPTH-1:0]       q_vld;
    reg_addr_bus [DEPTH-1:0] q_addr;
    logic                   q_empty;
    logic                   lu_acc;
    logic                   lu_nz;
    logic                   push;
    logic                   pop;
    logic [SW-1:0]          starve_cnt;
    logic [SW-1:0]          starve_nxt;

    assign q_empty    = (q_count == '0);
    assign lu_ready_o = (q_count != CW'(DEPTH));
    assign lu_acc     = lu_valid_i & lu_ready_o;
    assign lu_nz      = (lu_reg_addr_i != REG_ZERO_ADDR);

    // Bypass is suppressed while reset is held so only wb reaches the port then.
    always_comb begin
        w_reg_enable_o = WRITE_DISABLE;
        w_reg_addr_o   = REG_ZERO_ADDR;
        w_reg_data_o   = DATA_ZERO;
        pop            = 1'b0;
        push           = 1'b0;
        if (wb_w_reg_enable_i) begin
            w_reg_enable_o = WRITE_ENABLE;
            w_reg_addr_o   = wb_w_reg_addr_i;
            w_reg_data_o   = wb_w_reg_data_i;
            push           = lu_acc & lu_nz;
        end else if (!q_empty) begin
            w_reg_enable_o = WRITE_ENABLE;
            w_reg_addr_o   = q_head.addr;
            w_reg_data_o   = q_head.data;
            pop            = 1'b1;
            push           = lu_acc & lu_nz;
        end else if (lu_acc && lu_nz && rst_n) begin
            w_reg_enable_o = WRITE_ENABLE;
            w_reg_addr_o   = lu_reg_addr_i;
            w_reg_data_o   = lu_reg_data_i;
        end
    end

    rf_wq_fifo #(.DEPTH(DEPTH)) u_wq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ('{addr: lu_reg_addr_i, data: lu_reg_data_i}),
        .pop      (pop),
        .head_dat (q_head),
        .count    (q_count),
        .ent_vld  (q_vld),
        .ent_addr (q_addr)
    );

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] &&
                ((id_rs1_addr_i != REG_ZERO_ADDR && q_addr[i] == id_rs1_addr_i) ||
                 (id_rs2_addr_i != REG_ZERO_ADDR && q_addr[i] == id_rs2_addr_i) ||
                 (id_rd_addr_i  != REG_ZERO_ADDR && q_addr[i] == id_rd_addr_i)))
                hazard_o = 1'b1;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (q_empty || pop)
            starve_nxt = '0;
        else if (wb_w_reg_enable_i && starve_cnt != SW'(STARVE_LIMIT))
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            steal_o    <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            steal_o    <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with a queue-based reference model checked every cycle.
module tb_rf_wport_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rdd = '0;
    logic        hazard, steal, w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [4:0]  mq_addr[$];
    logic [31:0] mq_data[$];
    int          m_starve = 0;
    bit          m_steal  = 1'b0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wb_w_reg_enable_i (wb_en),
        .wb_w_reg_addr_i   (wb_addr),
        .wb_w_reg_data_i   (wb_data),
        .lu_valid_i        (lu_valid),
        .lu_ready_o        (lu_ready),
        .lu_reg_addr_i     (lu_addr),
        .lu_reg_data_i     (lu_data),
        .id_rs1_addr_i     (rs1),
        .id_rs2_addr_i     (rs2),
        .id_rd_addr_i      (rdd),
        .hazard_o          (hazard),
        .steal_o           (steal),
        .w_reg_enable_o    (w_en),
        .w_reg_addr_o      (w_addr),
        .w_reg_data_o      (w_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state advances on the clock from the queue/starvation rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_data.delete();
            m_starve = 0;
            m_steal  = 1'b0;
        end else begin
            bit had, popped, acc;
            had    = (mq_addr.size() > 0);
            acc    = lu_valid && (mq_addr.size() < DEPTH);
            popped = !wb_en && had;
            if (popped) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (acc && lu_addr != 5'd0 && (wb_en || had)) begin
                mq_addr.push_back(lu_addr);
                mq_data.push_back(lu_data);
            end
            if (!had || popped)            m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
            m_steal = (m_starve == STARVE_LIMIT);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_en, e_rdy, e_haz;
            logic [4:0]  e_a;
            logic [31:0] e_d;
            e_rdy = (mq_addr.size() < DEPTH);
            e_en = 1'b0; e_a = '0; e_d = '0;
            if (wb_en) begin
                e_en = 1'b1; e_a = wb_addr; e_d = wb_data;
            end else if (mq_addr.size() > 0) begin
                e_en = 1'b1; e_a = mq_addr[0]; e_d = mq_data[0];
            end else if (lu_valid && e_rdy && lu_addr != 5'd0 && rst_n) begin
                e_en = 1'b1; e_a = lu_addr; e_d = lu_data;
            end
            e_haz = 1'b0;
            foreach (mq_addr[i])
                if ((rs1 != 0 && mq_addr[i] == rs1) || (rs2 != 0 && mq_addr[i] == rs2) ||
                    (rdd != 0 && mq_addr[i] == rdd))
                    e_haz = 1'b1;
            chk("model_w_en",   32'(w_en),     32'(e_en));
            chk("model_w_addr", 32'(w_addr),   32'(e_a));
            chk("model_w_data", w_data,        e_d);
            chk("model_ready",  32'(lu_ready), 32'(e_rdy));
            chk("model_hazard", 32'(hazard),   32'(e_haz));
            chk("model_steal",  32'(steal),    32'(m_steal));
        end
    end

    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        @(posedge clk);
        #1;
        wb_en = we; wb_addr = wa; wb_data = wd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        rs1 = r1; rs2 = r2; rdd = rd;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        // Reset behaviour
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", 32'(lu_ready), 1); chk("rst_hazard", 32'(hazard), 0);
        chk("rst_steal", 32'(steal), 0);    chk("rst_w_en", 32'(w_en), 0);
        cyc(1, 3, 32'h99, 1, 6, 32'h66, 0, 0, 0);
        chk("rst_wb_en", 32'(w_en), 1);     chk("rst_wb_addr", 32'(w_addr), 3);
        cyc(0, 0, 0, 1, 6, 32'h66, 0, 0, 0);
        chk("rst_no_bypass", 32'(w_en), 0);
        #2 rst_n = 1'b1;

        // 1: bypass with wb idle
        cyc(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0);
        chk("t1_en", 32'(w_en), 1); chk("t1_addr", 32'(w_addr), 5);
        chk("t1_data", w_data, 32'h1234); chk("t1_hazard", 32'(hazard), 0);
        cyc(0, 0, 0, 0, 0, 0, 5, 0, 0);
        chk("t1_empty_en", 32'(w_en), 0); chk("t1_no_haz", 32'(hazard), 0);

        // 2: enqueue behind wb, hazard, in-order drain
        cyc(1, 1, 32'h11, 1, 7, 32'hA, 0, 0, 0);
        chk("t2_wb_addr", 32'(w_addr), 1);
        cyc(1, 1, 32'h12, 1, 8, 32'hB, 0, 0, 0);
        cyc(1, 1, 32'h13, 0, 0, 0, 7, 0, 0);
        chk("t2_full", 32'(lu_ready), 0); chk("t2_haz_rs1", 32'(hazard), 1);
        cyc(1, 1, 32'h14, 0, 0, 0, 0, 0, 8);
        chk("t2_haz_rd", 32'(hazard), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_pop1_addr", 32'(w_addr), 7); chk("t2_pop1_data", w_data, 32'hA);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_pop2_addr", 32'(w_addr), 8); chk("t2_pop2_data", w_data, 32'hB);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_idle", 32'(w_en), 0);

        // 3: starvation and port steal
        cyc(1, 2, 32'h20, 1, 9, 32'hC, 0, 0, 0);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            cyc(1, 2, 32'h21, 0, 0, 0, 0, 0, 0);
            chk("t3_no_steal", 32'(steal), 0);
        end
        cyc(1, 2, 32'h22, 0, 0, 0, 0, 0, 0);
        chk("t3_steal", 32'(steal), 1); chk("t3_wb_wins", 32'(w_addr), 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_head_addr", 32'(w_addr), 9); chk("t3_head_data", w_data, 32'hC);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_steal_clr", 32'(steal), 0);

        // 4: address-0 LU result is dropped
        cyc(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0);
        chk("t4_no_write", 32'(w_en), 0); chk("t4_ready", 32'(lu_ready), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_still_empty", 32'(w_en), 0);

        // 5: full with a coincident pop, then wrap
        cyc(1, 4, 32'h41, 1, 3, 32'h30, 0, 0, 0);
        cyc(1, 4, 32'h42, 1, 4, 32'h40, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 32'h50, 0, 0, 0);
        chk("t5_not_ready", 32'(lu_ready), 0); chk("t5_pop_addr", 32'(w_addr), 3);
        cyc(1, 4, 32'h43, 1, 5, 32'h50, 0, 0, 0);
        chk("t5_ready", 32'(lu_ready), 1);
        cyc(1, 4, 32'h44, 0, 0, 0, 0, 0, 0);
        chk("t5_full_again", 32'(lu_ready), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_pop_x4", 32'(w_addr), 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_pop_x5", 32'(w_addr), 5); chk("t5_pop_x5_d", w_data, 32'h50);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_drained", 32'(w_en), 0);

        // 6: asynchronous reset with two entries queued
        cyc(1, 6, 32'h60, 1, 10, 32'hAA, 0, 0, 0);
        cyc(1, 6, 32'h61, 1, 11, 32'hBB, 0, 0, 0);
        cyc(1, 6, 32'h62, 0, 0, 0, 10, 0, 0);
        chk("t6_pre_haz", 32'(hazard), 1); chk("t6_pre_full", 32'(lu_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_ready", 32'(lu_ready), 1); chk("t6_async_haz", 32'(hazard), 0);
        chk("t6_async_steal", 32'(steal), 0);
        cyc(0, 0, 0, 0, 0, 0, 10, 0, 0);
        chk("t6_rst_w_en", 32'(w_en), 0);
        #2 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 11, 0, 0);
        chk("t6_post_en", 32'(w_en), 0); chk("t6_post_haz", 32'(hazard), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
